// File: rtl/sort_pkg.sv
// Shared definitions for the sort block and its loader: state encoding and default sizes.
package sort_pkg;

    localparam int SORT_WIDTH   = 4;
    localparam int SORT_LED_W   = 8;
    localparam int SORT_N_ITEMS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_SORT,
        ST_SETTLE,
        ST_DONE
    } sort_loader_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sort_loader_if.sv
// Controller and sort-side signals of the loader; master is the loader, slave is whoever drives it.
interface sort_loader_if
    import sort_pkg::*;
#(
    parameter int N_ITEMS = SORT_N_ITEMS,
    parameter int WIDTH   = SORT_WIDTH,
    parameter int LED_W   = SORT_LED_W
) ();

    logic                       start;
    logic [N_ITEMS*WIDTH-1:0]   data_in;
    logic                       busy;
    logic                       done;
    logic [LED_W-1:0]           result;
    logic [WIDTH-1:0]           sw;
    logic                       key1;
    logic                       key2;
    logic [LED_W-1:0]           led;

    modport master (
        input  start, data_in, led,
        output busy, done, result, sw, key1, key2
    );

    modport slave (
        output start, data_in, led,
        input  busy, done, result, sw, key1, key2
    );

endinterface

// File: rtl/cycle_counter.sv
// Loadable down-counter that parks at zero; zero_o flags the last cycle of a timed phase.
module cycle_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sort_loader.sv
// Drives sort's switch/key inputs from a packed value list, fires the sort and captures led.
module sort_loader
    import sort_pkg::*;
#(
    parameter int N_ITEMS    = SORT_N_ITEMS,
    parameter int WIDTH      = SORT_WIDTH,
    parameter int LED_W      = SORT_LED_W,
    parameter int PULSE_CYC  = 1,
    parameter int GAP_CYC    = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    sort_loader_if.master   bus
);

    localparam int CNT_MAX = max3(PULSE_CYC, GAP_CYC, SETTLE_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ITEMS - 1);
    localparam logic [CW-1:0]    P_LD     = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]    G_LD     = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0]    S_LD     = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    sort_loader_state_t                 state_q;
    logic [N_ITEMS-1:0][WIDTH-1:0]      items_q;
    logic [IDX_W-1:0]                   idx_q;
    logic [WIDTH-1:0]                   sw_q;
    logic                               key1_q, key2_q, busy_q, done_q;
    logic [LED_W-1:0]                   result_q;

    logic            cnt_ld_d;
    logic [CW-1:0]   cnt_val_d;
    logic            cnt_zero;

    // Phase timer is reloaded on the same edge the FSM enters the timed state.
    always_comb begin
        cnt_ld_d  = 1'b0;
        cnt_val_d = P_LD;
        case (state_q)
            ST_IDLE: cnt_ld_d = bus.start;
            ST_LOAD: begin
                cnt_ld_d  = cnt_zero;
                cnt_val_d = G_LD;
            end
            ST_GAP:  cnt_ld_d = cnt_zero;
            ST_SORT: begin
                cnt_ld_d  = cnt_zero;
                cnt_val_d = S_LD;
            end
            default: ;
        endcase
    end

    cycle_counter #(.W(CW)) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_ld_d),
        .val_i  (cnt_val_d),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            items_q  <= '0;
            idx_q    <= '0;
            sw_q     <= '0;
            key1_q   <= 1'b0;
            key2_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    items_q <= bus.data_in;
                    idx_q   <= '0;
                    sw_q    <= bus.data_in[WIDTH-1:0];
                    key1_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: if (cnt_zero) begin
                    key1_q  <= 1'b0;
                    state_q <= ST_GAP;
                end
                ST_GAP: if (cnt_zero) begin
                    if (idx_q < IDX_LAST) begin
                        idx_q   <= idx_q + IDX_W'(1);
                        sw_q    <= items_q[idx_q + IDX_W'(1)];
                        key1_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        key2_q  <= 1'b1;
                        state_q <= ST_SORT;
                    end
                end
                ST_SORT: if (cnt_zero) begin
                    key2_q <= 1'b0;
                    if (SETTLE_CYC == 0) begin
                        result_q <= bus.led;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: if (cnt_zero) begin
                    result_q <= bus.led;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.sw     = sw_q;
    assign bus.key1   = key1_q;
    assign bus.key2   = key2_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_sort_loader.sv
// Random-stimulus bench for sort_loader: default and non-default instances against a timing-formula model.
module tb_sort_loader;
    import sort_pkg::*;

    typedef struct packed {
        logic [3:0] sw;
        logic       key1;
        logic       key2;
        logic       busy;
        logic       done;
        logic [7:0] result;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_loader_if #(.N_ITEMS(4), .WIDTH(4), .LED_W(8)) bus_a ();
    sort_loader_if #(.N_ITEMS(2), .WIDTH(4), .LED_W(8)) bus_b ();

    sort_loader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    sort_loader #(
        .N_ITEMS(2), .WIDTH(4), .LED_W(8),
        .PULSE_CYC(3), .GAP_CYC(2), .SETTLE_CYC(0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    int nvec = 0;
    int nerr = 0;
    logic [7:0] res_a = 8'h00;
    logic [7:0] res_b = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs t cycles after the accepting edge, straight from the pulse timing formulas.
    function automatic obs_t model(input int t, input int n, input int p, input int g, input int s,
                                   input logic [15:0] items, input logic [7:0] res);
        obs_t o;
        int per  = p + g;
        int last = n * per + p + s;
        int idx  = t / per;
        if (idx > n - 1) idx = n - 1;
        o.sw     = items[idx*4 +: 4];
        o.key1   = (t < n * per) && ((t % per) < p);
        o.key2   = (t >= n * per) && (t < n * per + p);
        o.busy   = (t < last);
        o.done   = (t == last);
        o.result = res;
        return o;
    endfunction

    function automatic obs_t get_a();
        return '{sw: bus_a.sw, key1: bus_a.key1, key2: bus_a.key2,
                 busy: bus_a.busy, done: bus_a.done, result: bus_a.result};
    endfunction

    function automatic obs_t get_b();
        return '{sw: bus_b.sw, key1: bus_b.key1, key2: bus_b.key2,
                 busy: bus_b.busy, done: bus_b.done, result: bus_b.result};
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        chk({tag, ".sw"},     32'(got.sw),     32'(exp.sw));
        chk({tag, ".key1"},   32'(got.key1),   32'(exp.key1));
        chk({tag, ".key2"},   32'(got.key2),   32'(exp.key2));
        chk({tag, ".busy"},   32'(got.busy),   32'(exp.busy));
        chk({tag, ".done"},   32'(got.done),   32'(exp.done));
        chk({tag, ".result"}, 32'(got.result), 32'(exp.result));
        chk({tag, ".ovl"},    32'(got.key1 & got.key2), 32'(0));
    endtask

    // mode 0: random led; 1: start pulses while busy/done; 2: led 11->22->33 around capture; 3: led A5 from cycle 9
    task automatic run_a(input logic [15:0] d, input int mode);
        logic [7:0] cap;
        int L = 11;
        cap = 8'h00;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.data_in = d;
        @(posedge clk);
        for (int t = 0; t <= L + 2; t++) begin
            @(negedge clk);
            if (t == L) res_a = cap;
            check_obs($sformatf("a%0d.t%0d", mode, t), get_a(), model(t, 4, 1, 1, 2, d, res_a));
            bus_a.start = (mode == 1) && (t == 2 || t == 10 || t == 11);
            if (mode == 1) bus_a.data_in = 16'($urandom);
            case (mode)
                2:       bus_a.led = (t + 1 < 11) ? 8'h11 : ((t + 1 == 11) ? 8'h22 : 8'h33);
                3:       bus_a.led = (t + 1 >= 9) ? 8'hA5 : 8'h00;
                default: bus_a.led = 8'($urandom);
            endcase
            if (t + 1 == L) cap = bus_a.led;
        end
        if (mode == 2) chk("cap_instant", 32'(bus_a.result), 32'h22);
        if (mode == 3) chk("default_res", 32'(bus_a.result), 32'hA5);
    endtask

    task automatic reset_mid();
        logic [15:0] d;
        d = 16'($urandom);
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.data_in = d;
        @(posedge clk);
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk);
            check_obs($sformatf("rm.t%0d", t), get_a(), model(t, 4, 1, 1, 2, d, res_a));
            bus_a.start = 1'b0;
            bus_a.led   = 8'($urandom);
            if (t == 4) rst = 1'b1;
        end
        @(negedge clk);
        check_obs("rm.rst", get_a(), '0);
        rst   = 1'b0;
        res_a = 8'h00;
        res_b = 8'h00;
        run_a(16'($urandom), 0);
    endtask

    task automatic cont_a();
        logic [15:0] d;
        logic [7:0]  cap;
        int tt;
        d   = 16'($urandom);
        cap = 8'h00;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.data_in = d;
        @(posedge clk);
        for (int t = 0; t < 39; t++) begin
            @(negedge clk);
            tt = t % 13;
            if (tt == 11) res_a = cap;
            check_obs($sformatf("ct.t%0d", t), get_a(), model(tt, 4, 1, 1, 2, d, res_a));
            bus_a.led = 8'($urandom);
            if (tt + 1 == 11) cap = bus_a.led;
        end
        bus_a.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_obs("ct.rst", get_a(), '0);
        rst   = 1'b0;
        res_a = 8'h00;
        res_b = 8'h00;
    endtask

    task automatic run_b(input logic [7:0] d);
        logic [7:0] cap;
        int L = 13;
        cap = 8'h00;
        @(negedge clk);
        bus_b.start   = 1'b1;
        bus_b.data_in = d;
        @(posedge clk);
        for (int t = 0; t <= L + 2; t++) begin
            @(negedge clk);
            if (t == L) res_b = cap;
            check_obs($sformatf("b.t%0d", t), get_b(), model(t, 2, 3, 2, 0, {8'h00, d}, res_b));
            bus_b.start   = 1'b0;
            bus_b.data_in = 8'($urandom);
            bus_b.led     = 8'($urandom);
            if (t + 1 == L) cap = bus_b.led;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus_a.start   = 1'b0;
        bus_a.data_in = '0;
        bus_a.led     = '0;
        bus_b.start   = 1'b0;
        bus_b.data_in = '0;
        bus_b.led     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_obs("rst_a", get_a(), '0);
        check_obs("rst_b", get_b(), '0);
        rst = 1'b0;

        run_a(16'h369F, 3);
        run_a(16'($urandom), 1);
        reset_mid();
        run_a(16'($urandom), 2);
        cont_a();
        run_b(8'hA5);
        run_b(8'($urandom));
        repeat (3) run_a(16'($urandom), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
